// File: rtl/jtag_stream_pkg.sv
// jtag_stream_pkg: shared FSM state type and beat field offsets for the JTAG vector stream front end.
package jtag_stream_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_RETURN} state_t;
    localparam int TMS_FIELD = 0;
    localparam int TDI_FIELD = 1;
endpackage

// File: rtl/jtag_vec_fifo.sv
// jtag_vec_fifo: show-ahead synchronous FIFO, power-of-2 depth, synchronous active-low flush.
module jtag_vec_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         dout
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    // A push while full is dropped even if a pop happens in the same cycle.
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign full   = r_count == (AW+1)'(DEPTH);
    assign empty  = r_count == '0;
    assign count  = r_count;
    assign dout   = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= din;
    end
endmodule

// File: rtl/jtag_vector_stream.sv
// jtag_vector_stream: AXI-Stream {TDI,TMS} prefetch front end driving the JTAG shifter handshake.
// Define JTAG_TDO_READBACK_EN to return each captured TDO vector on the master AXI-Stream.
module jtag_vector_stream
    import jtag_stream_pkg::*;
#(
    parameter int VEC_WIDTH           = 32,
    parameter int C_S_AXIS_DATA_WIDTH = 2*VEC_WIDTH,
    parameter int C_M_AXIS_DATA_WIDTH = VEC_WIDTH,
    parameter int PREFETCH_DEPTH      = 4,
    parameter int CNT_WIDTH           = 16
) (
    input  logic                           CLK,
    input  logic                           RESETN,
    output logic                           SHIFT_RESET,
    output logic                           ENABLE,
    input  logic                           DONE,
    output logic [VEC_WIDTH-1:0]           TMS_VECTOR,
    output logic [VEC_WIDTH-1:0]           TDI_VECTOR,
    input  logic [VEC_WIDTH-1:0]           TDO_VECTOR,
    input  logic                           S_AXIS_TVALID,
    output logic                           S_AXIS_TREADY,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                           S_AXIS_TLAST,
    output logic                           M_AXIS_TVALID,
    input  logic                           M_AXIS_TREADY,
    output logic [C_M_AXIS_DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                           M_AXIS_TLAST,
    output logic [CNT_WIDTH-1:0]           VEC_COUNT,
    output logic                           BUSY
);
    localparam int FW = C_S_AXIS_DATA_WIDTH + 1;

    state_t                       r_state;
    state_t                       w_state_next;
    logic                         r_out_of_reset;
    logic                         r_shift_reset;
    logic                         r_enable;
    logic [VEC_WIDTH-1:0]         r_tms;
    logic [VEC_WIDTH-1:0]         r_tdi;
    logic [CNT_WIDTH-1:0]         r_vec_count;
    logic                         w_full;
    logic                         w_empty;
    logic [$clog2(PREFETCH_DEPTH):0] w_count;
    logic [FW-1:0]                w_dout;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_done;
    logic                         w_ret;
    logic                         w_unused;

    jtag_vec_fifo #(.WIDTH(FW), .DEPTH(PREFETCH_DEPTH)) u_fifo (
        .clk    (CLK),
        .resetn (RESETN),
        .push   (w_push),
        .din    ({S_AXIS_TLAST, S_AXIS_TDATA}),
        .pop    (w_pop),
        .full   (w_full),
        .empty  (w_empty),
        .count  (w_count),
        .dout   (w_dout)
    );

    // TREADY stays low for the whole reset and the edge that releases it.
    assign S_AXIS_TREADY = r_out_of_reset & ~w_full;
    assign w_push        = S_AXIS_TVALID & S_AXIS_TREADY;
    assign w_pop         = (r_state == ST_IDLE) & ~w_empty;
    assign w_done        = (r_state == ST_RUN) & DONE;
    assign SHIFT_RESET   = r_shift_reset;
    assign ENABLE        = r_enable;
    assign TMS_VECTOR    = r_tms;
    assign TDI_VECTOR    = r_tdi;
    assign VEC_COUNT     = r_vec_count;
    assign BUSY          = r_state != ST_IDLE;

    always_comb begin
        w_state_next = r_state;
        if (w_pop) w_state_next = ST_RUN;
`ifdef JTAG_TDO_READBACK_EN
        else if (w_done) w_state_next = ST_RETURN;
        else if (w_ret) w_state_next = ST_IDLE;
`else
        else if (w_done) w_state_next = ST_IDLE;
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) r_state <= ST_IDLE;
        else r_state <= w_state_next;
    end

    always_ff @(posedge CLK) begin
        r_out_of_reset <= RESETN;
        if (!RESETN) begin
            r_shift_reset <= 1'b1;
            r_enable      <= 1'b0;
            r_tms         <= '0;
            r_tdi         <= '0;
            r_vec_count   <= '0;
        end else begin
            if (w_pop) begin
                r_tms         <= w_dout[TMS_FIELD*VEC_WIDTH +: VEC_WIDTH];
                r_tdi         <= w_dout[TDI_FIELD*VEC_WIDTH +: VEC_WIDTH];
                r_enable      <= 1'b1;
                r_shift_reset <= 1'b0;
            end
            if (w_done) begin
                r_enable      <= 1'b0;
                r_shift_reset <= 1'b1;
                r_vec_count   <= r_vec_count + CNT_WIDTH'(1);
            end
        end
    end

`ifdef JTAG_TDO_READBACK_EN
    logic                           r_last;
    logic                           r_m_valid;
    logic [C_M_AXIS_DATA_WIDTH-1:0] r_m_data;
    logic                           r_m_last;

    assign w_ret         = (r_state == ST_RETURN) & M_AXIS_TREADY;
    assign M_AXIS_TVALID = r_m_valid;
    assign M_AXIS_TDATA  = r_m_data;
    assign M_AXIS_TLAST  = r_m_last;
    assign w_unused      = ^w_count;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_last    <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
        end else begin
            if (w_pop) r_last <= w_dout[C_S_AXIS_DATA_WIDTH];
            if (w_done) begin
                r_m_data  <= C_M_AXIS_DATA_WIDTH'(TDO_VECTOR);
                r_m_last  <= r_last;
                r_m_valid <= 1'b1;
            end else if (w_ret) begin
                r_m_valid <= 1'b0;
            end
        end
    end
`else
    assign w_ret         = 1'b0;
    assign M_AXIS_TVALID = 1'b0;
    assign M_AXIS_TDATA  = '0;
    assign M_AXIS_TLAST  = 1'b0;
    assign w_unused      = ^{w_count, M_AXIS_TREADY, TDO_VECTOR, w_dout[C_S_AXIS_DATA_WIDTH], w_ret};
`endif
endmodule
